// File: rtl/qupls_fpu_seq_pkg.sv
// QuplsPkg: shared Qupls types plus the FPU
// sequencer state and captured-operation bundle.
package QuplsPkg;

  typedef logic [5:0]  rob_ndx_t;
  typedef logic [8:0]  pregno_t;
  typedef logic [6:0]  aregno_t;
  typedef logic [63:0] value_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB0,
    WB1
  } fpu_seq_state_t;

  typedef struct packed {
    rob_ndx_t   id;
    pregno_t    Rt;
    pregno_t    Rt1;
    aregno_t    aRt;
    aregno_t    aRt1;
    logic       aRtz;
    logic       aRtz1;
    logic       qfext;
    logic [7:0] cptgt;
  } fpu_op_t;

endpackage

// File: rtl/qupls_fpu_seq_if.sv
// Writeback request channel between the FPU
// sequencer and the writeback arbiter.
interface qupls_fpu_seq_if #(
  parameter int WID = 64
);
  import QuplsPkg::*;

  logic           wrv;
  logic           wack;
  rob_ndx_t       wid;
  pregno_t        wRt;
  aregno_t        waRt;
  logic           wz;
  logic [WID-1:0] wres;
  logic           wexc;
  logic           wlast;

  modport master (
    output wrv, wid, wRt, waRt,
    output wz, wres, wexc, wlast,
    input  wack
  );

  modport slave (
    input  wrv, wid, wRt, waRt,
    input  wz, wres, wexc, wlast,
    output wack
  );

endinterface

// File: rtl/qupls_fpu_lane_merge.sv
// Per-byte select between an old target value
// and a new result; a set mask bit keeps the old byte.
module qupls_fpu_lane_merge #(
  parameter int WID = 64
) (
  input  logic [WID/8-1:0] mask,
  input  logic [WID-1:0]   old_val,
  input  logic [WID-1:0]   new_val,
  output logic [WID-1:0]   merged
);

  for (genvar i = 0; i < WID/8; i++) begin : g_lane
    assign merged[i*8 +: 8] = mask[i]
      ? old_val[i*8 +: 8]
      : new_val[i*8 +: 8];
  end

endmodule

// File: rtl/qupls_fpu_seq.sv
// FPU operation sequencer: issues to the multicycle
// core or completes at once, then writes back 1-2 results.
module qupls_fpu_seq
  import QuplsPkg::*;
#(
  parameter int WID = 64,
  parameter int TMO = 63
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  rob_ndx_t       id,
  input  pregno_t        Rt,
  input  pregno_t        Rt1,
  input  aregno_t        aRt,
  input  aregno_t        aRt1,
  input  logic           aRtz,
  input  logic           aRtz1,
  input  logic           qfext,
  input  logic [7:0]     cptgt,
  input  logic           sc_done,
  input  logic [WID-1:0] argT,
  input  logic [WID-1:0] sc_res,
  output logic           fpu_ld,
  input  logic           fpu_done,
  input  logic [WID-1:0] fpu_res,
  input  logic [WID-1:0] fpu_res1,
  input  logic           fpu_exc,
  input  logic           flush,
  output logic           idle,
  qupls_fpu_seq_if.master wb
);

  localparam int CW = $clog2(TMO + 1);

  fpu_seq_state_t state, state_n;
  fpu_op_t        op, op_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [WID-1:0] argt_q, argt_n;
  logic [WID-1:0] res0, res0_n;
  logic [WID-1:0] res1, res1_n;
  logic           exc, exc_n;
  logic           ld_n;
  logic [WID-1:0] merged;

  qupls_fpu_lane_merge #(.WID(WID)) u_merge (
    .mask    (op_n.cptgt),
    .old_val (argt_n),
    .new_val (res0_n),
    .merged  (merged)
  );

  always_comb begin
    state_n = state;
    op_n    = op;
    argt_n  = argt_q;
    res0_n  = res0;
    res1_n  = res1;
    exc_n   = exc;
    cnt_n   = '0;
    ld_n    = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        op_n.id    = id;
        op_n.Rt    = Rt;
        op_n.Rt1   = Rt1;
        op_n.aRt   = aRt;
        op_n.aRt1  = aRt1;
        op_n.aRtz  = aRtz;
        op_n.aRtz1 = aRtz1;
        op_n.qfext = qfext;
        op_n.cptgt = cptgt;
        argt_n     = argT;
        res1_n     = '0;
        exc_n      = 1'b0;
        if (sc_done || &cptgt) begin
          res0_n  = sc_res;
          state_n = WB0;
        end else begin
          res0_n  = '0;
          ld_n    = 1'b1;
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (fpu_done) begin
          res0_n  = fpu_res;
          res1_n  = fpu_res1;
          exc_n   = fpu_exc;
          state_n = WB0;
        end else if (cnt == CW'(TMO)) begin
          res0_n  = '0;
          res1_n  = '0;
          exc_n   = 1'b1;
          state_n = WB0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WB0: if (wb.wack)
        state_n = op.qfext ? WB1 : IDLE;
      WB1: if (wb.wack)
        state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // flush outranks start and wack
    if (flush) begin
      state_n = IDLE;
      ld_n    = 1'b0;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      op       <= '0;
      cnt      <= '0;
      argt_q   <= '0;
      res0     <= '0;
      res1     <= '0;
      exc      <= 1'b0;
      fpu_ld   <= 1'b0;
      idle     <= 1'b1;
      wb.wrv   <= 1'b0;
      wb.wlast <= 1'b0;
      wb.wexc  <= 1'b0;
      wb.wz    <= 1'b1;
      wb.wid   <= '0;
      wb.wRt   <= '0;
      wb.waRt  <= '0;
      wb.wres  <= '0;
    end else begin
      state    <= state_n;
      op       <= op_n;
      cnt      <= cnt_n;
      argt_q   <= argt_n;
      res0     <= res0_n;
      res1     <= res1_n;
      exc      <= exc_n;
      fpu_ld   <= ld_n;
      idle     <= state_n == IDLE;
      wb.wrv   <= state_n == WB0 ||
                  state_n == WB1;
      wb.wlast <= state_n == WB1 ||
                  (state_n == WB0 && !op_n.qfext);
      wb.wexc  <= exc_n &&
                  (state_n == WB0 || state_n == WB1);
      if (state_n == WB0) begin
        wb.wid  <= op_n.id;
        wb.wRt  <= op_n.Rt;
        wb.waRt <= op_n.aRt;
        wb.wz   <= op_n.aRtz;
        wb.wres <= merged;
      end else if (state_n == WB1) begin
        wb.wid  <= op_n.id;
        wb.wRt  <= op_n.Rt1;
        wb.waRt <= op_n.aRt1;
        wb.wz   <= op_n.aRtz1;
        wb.wres <= res1_n;
      end
    end
  end

endmodule

// File: tb/tb_qupls_fpu_seq.sv
// Directed bench for qupls_fpu_seq: single-cycle,
// multicycle merge, qfext, stall, timeout, flush, reset.
module tb_qupls_fpu_seq;
  import QuplsPkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  rob_ndx_t    id;
  pregno_t     Rt, Rt1;
  aregno_t     aRt, aRt1;
  logic        aRtz, aRtz1, qfext;
  logic [7:0]  cptgt;
  logic        sc_done;
  logic [63:0] argT, sc_res;
  logic        fpu_ld, fpu_done, fpu_exc;
  logic [63:0] fpu_res, fpu_res1;
  logic        flush, idle;

  int checks = 0;
  int errors = 0;

  qupls_fpu_seq_if #(.WID(64)) wb ();

  qupls_fpu_seq #(.WID(64), .TMO(63)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .id       (id),
    .Rt       (Rt),
    .Rt1      (Rt1),
    .aRt      (aRt),
    .aRt1     (aRt1),
    .aRtz     (aRtz),
    .aRtz1    (aRtz1),
    .qfext    (qfext),
    .cptgt    (cptgt),
    .sc_done  (sc_done),
    .argT     (argT),
    .sc_res   (sc_res),
    .fpu_ld   (fpu_ld),
    .fpu_done (fpu_done),
    .fpu_res  (fpu_res),
    .fpu_res1 (fpu_res1),
    .fpu_exc  (fpu_exc),
    .flush    (flush),
    .idle     (idle),
    .wb       (wb.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; id = '0;
    Rt = '0; Rt1 = '0; aRt = '0; aRt1 = '0;
    aRtz = 1'b0; aRtz1 = 1'b0; qfext = 1'b0;
    cptgt = '0; sc_done = 1'b0;
    argT = '0; sc_res = '0;
    fpu_done = 1'b0; fpu_exc = 1'b0;
    fpu_res = '0; fpu_res1 = '0;
    flush = 1'b0; wb.wack = 1'b0;
    tick();
    tick();
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_wrv", 64'(wb.wrv), 64'd0);
    chk("rst_ld", 64'(fpu_ld), 64'd0);
    chk("rst_wz", 64'(wb.wz), 64'd1);
    chk("rst_wlast", 64'(wb.wlast), 64'd0);
    chk("rst_wexc", 64'(wb.wexc), 64'd0);
    chk("rst_wres", wb.wres, 64'd0);
    rst = 1'b1;
    tick();

    // single-cycle path
    start = 1'b1; sc_done = 1'b1; cptgt = 8'h00;
    sc_res = 64'h1234; Rt = 9'd5; id = 6'd3;
    aRt = 7'd9;
    tick();
    start = 1'b0;
    chk("sc_wrv", 64'(wb.wrv), 64'd1);
    chk("sc_wres", wb.wres, 64'h1234);
    chk("sc_wRt", 64'(wb.wRt), 64'd5);
    chk("sc_wid", 64'(wb.wid), 64'd3);
    chk("sc_waRt", 64'(wb.waRt), 64'd9);
    chk("sc_wz", 64'(wb.wz), 64'd0);
    chk("sc_wlast", 64'(wb.wlast), 64'd1);
    chk("sc_idle", 64'(idle), 64'd0);
    chk("sc_ld", 64'(fpu_ld), 64'd0);
    wb.wack = 1'b1;
    tick();
    wb.wack = 1'b0;
    chk("sc_idle2", 64'(idle), 64'd1);
    chk("sc_wrv2", 64'(wb.wrv), 64'd0);

    // multicycle with byte merge
    start = 1'b1; sc_done = 1'b0; cptgt = 8'h0F;
    argT = 64'hAAAA_AAAA_AAAA_AAAA;
    Rt = 9'd10; id = 6'd4;
    tick();
    start = 1'b0;
    chk("mc_ld1", 64'(fpu_ld), 64'd1);
    chk("mc_idle1", 64'(idle), 64'd0);
    chk("mc_wrv1", 64'(wb.wrv), 64'd0);
    tick();
    chk("mc_ld2", 64'(fpu_ld), 64'd0);
    tick();
    tick();
    tick();
    tick();
    chk("mc_wrv6", 64'(wb.wrv), 64'd0);
    fpu_done = 1'b1;
    fpu_res = 64'h1111_2222_3333_4444;
    tick();
    fpu_done = 1'b0;
    chk("mc_wrv7", 64'(wb.wrv), 64'd1);
    chk("mc_wres", wb.wres, 64'h1111_2222_AAAA_AAAA);
    chk("mc_wexc", 64'(wb.wexc), 64'd0);
    chk("mc_wlast", 64'(wb.wlast), 64'd1);

    // backpressure with an ignored start
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        start = 1'b1; sc_done = 1'b1;
        Rt = 9'd20; sc_res = 64'hDEAD;
        cptgt = 8'h00;
      end
      tick();
      start = 1'b0;
      chk("bp_wrv", 64'(wb.wrv), 64'd1);
      chk("bp_wres", wb.wres,
          64'h1111_2222_AAAA_AAAA);
      chk("bp_wRt", 64'(wb.wRt), 64'd10);
    end
    wb.wack = 1'b1;
    tick();
    wb.wack = 1'b0;
    chk("bp_idle", 64'(idle), 64'd1);
    chk("bp_wrv_end", 64'(wb.wrv), 64'd0);
    tick();
    chk("bp_no_ghost", 64'(wb.wrv), 64'd0);

    // qfext: two writebacks back to back
    start = 1'b1; sc_done = 1'b0; cptgt = 8'h00;
    qfext = 1'b1; Rt = 9'd7; Rt1 = 9'd8;
    tick();
    start = 1'b0;
    tick();
    fpu_done = 1'b1; fpu_res = 64'h99;
    fpu_res1 = 64'h55; wb.wack = 1'b1;
    tick();
    fpu_done = 1'b0;
    chk("qx_wrv0", 64'(wb.wrv), 64'd1);
    chk("qx_wRt0", 64'(wb.wRt), 64'd7);
    chk("qx_wres0", wb.wres, 64'h99);
    chk("qx_wlast0", 64'(wb.wlast), 64'd0);
    tick();
    chk("qx_wrv1", 64'(wb.wrv), 64'd1);
    chk("qx_wRt1", 64'(wb.wRt), 64'd8);
    chk("qx_wres1", wb.wres, 64'h55);
    chk("qx_wlast1", 64'(wb.wlast), 64'd1);
    tick();
    wb.wack = 1'b0;
    chk("qx_wrv2", 64'(wb.wrv), 64'd0);
    chk("qx_idle", 64'(idle), 64'd1);

    // timeout
    start = 1'b1; sc_done = 1'b0; cptgt = 8'h00;
    qfext = 1'b0; Rt = 9'd12;
    fpu_res = 64'hFFFF; argT = 64'h7777;
    tick();
    start = 1'b0;
    chk("to_ld", 64'(fpu_ld), 64'd1);
    for (int i = 0; i < 63; i++) tick();
    chk("to_wrv64", 64'(wb.wrv), 64'd0);
    tick();
    chk("to_wrv65", 64'(wb.wrv), 64'd1);
    chk("to_wres", wb.wres, 64'd0);
    chk("to_wexc", 64'(wb.wexc), 64'd1);
    wb.wack = 1'b1;
    tick();
    wb.wack = 1'b0;
    chk("to_idle", 64'(idle), 64'd1);
    chk("to_wexc_clr", 64'(wb.wexc), 64'd0);

    // flush beats wack in WB0
    start = 1'b1; sc_done = 1'b1; qfext = 1'b1;
    Rt = 9'd7; Rt1 = 9'd8; sc_res = 64'h42;
    tick();
    start = 1'b0;
    chk("fl_wrv", 64'(wb.wrv), 64'd1);
    wb.wack = 1'b1; flush = 1'b1;
    tick();
    wb.wack = 1'b0; flush = 1'b0;
    chk("fl_wrv_drop", 64'(wb.wrv), 64'd0);
    chk("fl_idle", 64'(idle), 64'd1);
    tick();
    chk("fl_no_wb1", 64'(wb.wrv), 64'd0);

    // async reset in EXEC
    start = 1'b1; sc_done = 1'b0; qfext = 1'b0;
    cptgt = 8'h00;
    tick();
    start = 1'b0;
    tick();
    chk("ar_busy", 64'(idle), 64'd0);
    #1 rst = 1'b0;
    #1;
    chk("ar_idle", 64'(idle), 64'd1);
    chk("ar_wrv", 64'(wb.wrv), 64'd0);
    #1 rst = 1'b1;
    fpu_done = 1'b1; fpu_res = 64'hBEEF;
    tick();
    fpu_done = 1'b0;
    chk("ar_done_ign", 64'(wb.wrv), 64'd0);
    chk("ar_idle2", 64'(idle), 64'd1);
    tick();
    chk("ar_wrv3", 64'(wb.wrv), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/qupls_fpu_seq.md
# qupls_fpu_seq

FPU operation sequencer for Qupls, downstream of the FPU reservation station. It accepts one latched FPU operation from the station, either completes it at once (single-cycle or full-copy ops) or drives an external multicycle FPU core and waits for its result. It then merges copy-target byte lanes and presents one or two results (two when `qfext`) to the writeback arbiter under a valid/ack handshake. It returns `idle` to the station so the station can accept its next instruction.

## Interface
Parameters:
- `WID`, 64: result width; 8 byte lanes, one per `cptgt` bit.
- `TMO`, 63: cycles to wait for `fpu_done` before forcing an exception writeback.

Ports:
- `clk  in  1`: clock.
- `rst  in  1`: reset. One clock; reset is asynchronous and active-low.
- `start  in  1`: station loaded a new operation this cycle; fields below are valid.
- `id  in  rob_ndx_t`: ROB index of the operation.
- `Rt`, `Rt1  in  pregno_t`: physical targets for result 0 and result 1.
- `aRt`, `aRt1  in  aregno_t`: architectural targets.
- `aRtz`, `aRtz1  in  1`: architectural target is r0; suppresses register write.
- `qfext  in  1`: operation produces a second result.
- `cptgt  in  8`: per-byte copy mask; 1 selects the `argT` byte.
- `sc_done  in  1`: operation needs no FPU core cycles.
- `argT  in  WID`: old target value used for the byte merge.
- `sc_res  in  WID`: single-cycle result.
- `fpu_ld  out  1`: one-cycle pulse that starts the FPU core.
- `fpu_done  in  1`: core result valid.
- `fpu_res`, `fpu_res1  in  WID`: core results.
- `fpu_exc  in  1`: core raised an exception.
- `flush  in  1`: pipeline flush; abort the current operation.
- `idle  out  1`: sequencer can take `start`.
- `wrv  out  1`: writeback request valid.
- `wack  in  1`: arbiter accepts the current writeback.
- `wid  out  rob_ndx_t`, `wRt  out  pregno_t`, `waRt  out  aregno_t`, `wz  out  1`, `wres  out  WID`, `wexc  out  1`: writeback payload.
- `wlast  out  1`: final writeback of this operation; the ROB entry may be marked done.

## Operation
- States: IDLE, EXEC, WB0, WB1.
- IDLE with `start`:
  - Capture all input fields.
  - If `sc_done` or `&cptgt`: go to WB0 with result `sc_res`.
  - Otherwise: go to EXEC and pulse `fpu_ld` for one cycle on entry.
- `start` outside IDLE is ignored.
- EXEC:
  - Count cycles from 0.
  - On `fpu_done`: capture `fpu_res`, `fpu_res1` and `fpu_exc`, then go to WB0.
  - When the count reaches `TMO` with no `fpu_done`: go to WB0 with result 0 and `wexc`=1.
- Byte merge:
  - `wres` byte i = `argT` byte i if `cptgt[i]`, else the result byte i.
  - The merge applies to result 0 only; result 1 passes through unmerged.
- WB0:
  - `wrv`=1 with `Rt`, `aRt`, `aRtz` and the merged result.
  - `wlast` = !`qfext`.
  - On `wack`: go to WB1 if `qfext`, else IDLE.
- WB1:
  - `wrv`=1 with `Rt1`, `aRt1`, `aRtz1`, `fpu_res1`, `wlast`=1.
  - `wexc` is the captured exception.
  - On `wack`: go to IDLE.
- `flush` in any state: go to IDLE next cycle and drop any pending writeback. `flush` beats a same-cycle `wack`, so the arbiter must also qualify with `flush`. `flush` beats a same-cycle `start`.
- A `fpu_done` that arrives in any state other than EXEC is ignored.

## Timing
- Reset: state IDLE; `idle`=1; `fpu_ld`=0; `wrv`=0; `wlast`=0; `wexc`=0; `wz`=1; all payload and captured registers 0; timeout counter 0.
- All outputs are registered.
- `idle` falls in the cycle after `start` and rises in the cycle after the final `wack` or a `flush`.
- Single-cycle path: `start` at cycle 0, `wrv` at cycle 1; with `wack` at cycle 1, `idle` at cycle 2. This gives back-to-back issue every 2 cycles.
- Multicycle path:
  - `start` at cycle 0; `fpu_ld` high at cycle 1 only.
  - `fpu_done` at cycle N (N≥1); `wrv` at cycle N+1.
- `wrv` and the payload hold stable until `wack`.
- `qfext`: WB1 follows in the cycle after the WB0 `wack`. There is no bubble between the two writebacks.
- Timeout: counter at `TMO` in EXEC means WB0 on the next cycle. The counter saturates and clears on leaving EXEC.
- Asynchronous reset mid-operation returns to IDLE immediately; no writeback is issued.

## Structure
- `fpu_seq_state_t` (IDLE, EXEC, WB0, WB1) goes in QuplsPkg. The package already provides `rob_ndx_t`, `pregno_t`, `aregno_t` and `value_t`.
- The byte merge is one small combinational sub-module, `qupls_fpu_lane_merge` (mask, old value, new value → merged value), reusable by other stations.
- The FSM, capture registers and timeout counter live in the top module.

## Test plan
- Single-cycle: `start` with `sc_done`=1, `cptgt`=0, `sc_res`=64'h1234, `Rt`=5, `id`=3 → `wrv` at cycle 1 with `wres`=64'h1234, `wRt`=5, `wid`=3, `wlast`=1; `wack` at cycle 1 → `idle`=1 at cycle 2.
- Multicycle with merge: `cptgt`=8'h0F, `argT`=64'hAAAA_AAAA_AAAA_AAAA; `fpu_done` at cycle 6 with `fpu_res`=64'h1111_2222_3333_4444 → `fpu_ld` high only at cycle 1; `wres`=64'h1111_2222_AAAA_AAAA at cycle 7.
- `qfext`: `Rt`=7, `Rt1`=8, `fpu_res1`=64'h55; `wack` held high → writebacks on consecutive cycles to 7 (`wlast`=0) then 8 (`wres`=64'h55, `wlast`=1).
- Backpressure: `wack` low for 4 cycles → `wrv` and the payload stay constant; a `start` pulse during the stall is ignored.
- Timeout: `TMO`=63, `fpu_done` never asserted → WB0 with `wres`=0 (`cptgt`=0), `wexc`=1, entered 64 cycles after `fpu_ld`.
- Flush and reset: `flush` with `wack` in the same WB0 cycle → IDLE next cycle, no WB1. `rst` low in EXEC → `wrv`=0 and `idle`=1 immediately; a later `fpu_done` is ignored.
